// File: rtl/logistic_pkg.sv
// Shared widths and FSM encoding for the logistic unit arbiter.
package logistic_pkg;

    localparam int ARGUMENT_WIDTH   = 16;
    localparam int ACTIVATION_WIDTH = 8;
    localparam int FEEDBACK_WIDTH   = 16;
    localparam int DELTA_WIDTH      = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARGUMENT,
        ACTIVATION,
        FEEDBACK,
        DELTA
    } state_t;

endpackage

// File: rtl/logistic_arbiter_round_robin.sv
// Combinational round-robin picker: first requester at or after last+1 (mod N).
module round_robin #(
    parameter  int N = 4,
    localparam int G = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [G-1:0] last_i,
    output logic [G-1:0] next_o,
    output logic         any_o
);

    logic         found;
    logic [G-1:0] idx;

    always_comb begin
        next_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int unsigned i = 1; i <= N; i++) begin
            idx = G'((32'(last_i) + i) % N);
            if (!found && req_i[idx]) begin
                next_o = idx;
                found  = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/logistic_arbiter.sv
// Shares one logistic activation unit among N neuron requesters, one full
// transaction (argument, activation, optional feedback/delta) per grant.
module logistic_arbiter
    import logistic_pkg::*;
#(
    parameter  int N = 4,
    localparam int G = $clog2(N)
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             train,
    input  logic [N-1:0]                     req_argument_valid,
    output logic [N-1:0]                     req_argument_ready,
    input  logic [N-1:0][ARGUMENT_WIDTH-1:0] req_argument_data,
    input  logic [N-1:0]                     req_feedback_valid,
    output logic [N-1:0]                     req_feedback_ready,
    input  logic [N-1:0][FEEDBACK_WIDTH-1:0] req_feedback_data,
    output logic [N-1:0]                     req_activation_valid,
    input  logic [N-1:0]                     req_activation_ready,
    output logic [ACTIVATION_WIDTH-1:0]      req_activation_data,
    output logic [N-1:0]                     req_delta_valid,
    input  logic [N-1:0]                     req_delta_ready,
    output logic [DELTA_WIDTH-1:0]           req_delta_data,
    output logic                             logistic_train,
    output logic                             argument_valid,
    output logic [ARGUMENT_WIDTH-1:0]        argument_data,
    input  logic                             argument_ready,
    output logic                             feedback_valid,
    output logic [FEEDBACK_WIDTH-1:0]        feedback_data,
    input  logic                             feedback_ready,
    input  logic                             activation_valid,
    input  logic [ACTIVATION_WIDTH-1:0]      activation_data,
    output logic                             activation_ready,
    input  logic                             delta_valid,
    input  logic [DELTA_WIDTH-1:0]           delta_data,
    output logic                             delta_ready,
    output logic [G-1:0]                     grant,
    output logic                             busy
);

    state_t       state_q, state_d;
    logic [G-1:0] last_q, last_d;
    logic [G-1:0] grant_q, grant_d;
    logic         train_q, train_d;
    logic [G-1:0] rr_next;
    logic         rr_any;

    round_robin #(.N(N)) u_round_robin (
        .req_i  (req_argument_valid),
        .last_i (last_q),
        .next_o (rr_next),
        .any_o  (rr_any)
    );

    // last resets to N-1 so requester 0 holds first priority out of reset
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            last_q  <= G'(N - 1);
            grant_q <= '0;
            train_q <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            train_q <= train_d;
        end
    end

    always_comb begin
        state_d              = state_q;
        last_d               = last_q;
        grant_d              = grant_q;
        train_d              = train_q;
        argument_valid       = 1'b0;
        feedback_valid       = 1'b0;
        activation_ready     = 1'b0;
        delta_ready          = 1'b0;
        req_argument_ready   = '0;
        req_feedback_ready   = '0;
        req_activation_valid = '0;
        req_delta_valid      = '0;
        case (state_q)
            IDLE: begin
                if (rr_any) begin
                    grant_d = rr_next;
                    train_d = train;
                    state_d = ARGUMENT;
                end
            end
            ARGUMENT: begin
                argument_valid              = req_argument_valid[grant_q];
                req_argument_ready[grant_q] = argument_ready;
                if (req_argument_valid[grant_q] && argument_ready) begin
                    state_d = ACTIVATION;
                end
            end
            ACTIVATION: begin
                req_activation_valid[grant_q] = activation_valid;
                activation_ready              = req_activation_ready[grant_q];
                if (activation_valid && req_activation_ready[grant_q]) begin
                    if (train_q) begin
                        state_d = FEEDBACK;
                    end else begin
                        last_d  = grant_q;
                        state_d = IDLE;
                    end
                end
            end
            FEEDBACK: begin
                feedback_valid              = req_feedback_valid[grant_q];
                req_feedback_ready[grant_q] = feedback_ready;
                if (req_feedback_valid[grant_q] && feedback_ready) begin
                    state_d = DELTA;
                end
            end
            DELTA: begin
                req_delta_valid[grant_q] = delta_valid;
                delta_ready              = req_delta_ready[grant_q];
                if (delta_valid && req_delta_ready[grant_q]) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign argument_data       = req_argument_data[grant_q];
    assign feedback_data       = req_feedback_data[grant_q];
    assign req_activation_data = activation_data;
    assign req_delta_data      = delta_data;
    assign grant               = grant_q;
    assign busy                = (state_q != IDLE);
    assign logistic_train      = train_q;

endmodule

// File: tb/tb_logistic_arbiter.sv
// Scoreboard bench for logistic_arbiter with a behavioural logistic unit.
module tb_logistic_arbiter;

    localparam int N = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              train;
    logic [N-1:0]      req_argument_valid, req_argument_ready;
    logic [N-1:0][15:0] req_argument_data;
    logic [N-1:0]      req_feedback_valid, req_feedback_ready;
    logic [N-1:0][15:0] req_feedback_data;
    logic [N-1:0]      req_activation_valid, req_activation_ready;
    logic [7:0]        req_activation_data;
    logic [N-1:0]      req_delta_valid, req_delta_ready;
    logic [15:0]       req_delta_data;
    logic              logistic_train;
    logic              argument_valid, argument_ready;
    logic [15:0]       argument_data;
    logic              feedback_valid, feedback_ready;
    logic [15:0]       feedback_data;
    logic              activation_valid, activation_ready;
    logic [7:0]        activation_data;
    logic              delta_valid, delta_ready;
    logic [15:0]       delta_data;
    logic [1:0]        grant;
    logic              busy;

    always #5 clock = ~clock;

    logistic_arbiter #(.N(N)) dut (
        .clock(clock), .reset(reset), .train(train),
        .req_argument_valid(req_argument_valid), .req_argument_ready(req_argument_ready),
        .req_argument_data(req_argument_data),
        .req_feedback_valid(req_feedback_valid), .req_feedback_ready(req_feedback_ready),
        .req_feedback_data(req_feedback_data),
        .req_activation_valid(req_activation_valid), .req_activation_ready(req_activation_ready),
        .req_activation_data(req_activation_data),
        .req_delta_valid(req_delta_valid), .req_delta_ready(req_delta_ready),
        .req_delta_data(req_delta_data),
        .logistic_train(logistic_train),
        .argument_valid(argument_valid), .argument_data(argument_data), .argument_ready(argument_ready),
        .feedback_valid(feedback_valid), .feedback_data(feedback_data), .feedback_ready(feedback_ready),
        .activation_valid(activation_valid), .activation_data(activation_data),
        .activation_ready(activation_ready),
        .delta_valid(delta_valid), .delta_data(delta_data), .delta_ready(delta_ready),
        .grant(grant), .busy(busy)
    );

    typedef struct {
        int          kind;   // 0 activation, 1 delta
        int          idx;
        logic [15:0] data;
    } exp_t;

    exp_t         sbq[$];
    int           checks = 0;
    int           errors = 0;
    logic [N-1:0] hold;
    int           st_grant[$];
    int           st_train[$];
    int           st_gap[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic expect_out(input int kind, input int idx, input logic [15:0] data);
        exp_t e;
        e.kind = kind;
        e.idx  = idx;
        e.data = data;
        sbq.push_back(e);
    endtask

    function automatic logic [7:0] unit_act(input logic [15:0] a);
        case (a)
            16'h0000: return 8'h80;
            16'h0600: return 8'hff;
            default:  return a[7:0];
        endcase
    endfunction

    function automatic logic [15:0] unit_delta(input logic [15:0] f);
        if (f == 16'hfe00) return 16'h0000;
        return ~f;
    endfunction

    // Behavioural logistic unit: one outstanding argument, responds next cycle.
    initial begin
        logic a_hs, c_hs, f_hs, d_hs;
        logic [15:0] a_d, f_d;
        argument_ready   = 1'b1;
        feedback_ready   = 1'b1;
        activation_valid = 1'b0;
        activation_data  = '0;
        delta_valid      = 1'b0;
        delta_data       = '0;
        forever begin
            @(negedge clock);
            a_hs = argument_valid & argument_ready;
            c_hs = activation_valid & activation_ready;
            f_hs = feedback_valid & feedback_ready;
            d_hs = delta_valid & delta_ready;
            a_d  = argument_data;
            f_d  = feedback_data;
            @(posedge clock);
            #1;
            if (!reset) begin
                argument_ready   = 1'b1;
                activation_valid = 1'b0;
                delta_valid      = 1'b0;
            end else begin
                if (c_hs) begin
                    activation_valid = 1'b0;
                    argument_ready   = 1'b1;
                end
                if (a_hs) begin
                    activation_valid = 1'b1;
                    activation_data  = unit_act(a_d);
                    argument_ready   = 1'b0;
                end
                if (d_hs) delta_valid = 1'b0;
                if (f_hs) begin
                    delta_valid = 1'b1;
                    delta_data  = unit_delta(f_d);
                end
            end
        end
    end

    task automatic check_out(input int kind, input logic [N-1:0] v, input logic [15:0] d);
        int   idx;
        exp_t e;
        idx = -1;
        for (int k = 0; k < N; k++) if (v[k]) idx = k;
        chk(kind == 0 ? "act_onehot" : "delta_onehot", 32'($onehot(v)), 32'd1);
        chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk(kind == 0 ? "activation_out" : "delta_out",
                {8'(kind), 8'(idx), d}, {8'(e.kind), 8'(e.idx), e.data});
        end
    endtask

    // Monitor: every requester-side output beat (ready tied high) pops the scoreboard.
    initial begin
        forever begin
            @(negedge clock);
            if (reset) begin
                if (req_activation_valid != '0)
                    check_out(0, req_activation_valid, {8'h00, req_activation_data});
                if (req_delta_valid != '0)
                    check_out(1, req_delta_valid, req_delta_data);
            end
        end
    end

    task automatic tick();
        logic [N-1:0] hs_a, hs_f;
        @(negedge clock);
        hs_a = req_argument_valid & req_argument_ready;
        hs_f = req_feedback_valid & req_feedback_ready;
        @(posedge clock);
        #1;
        req_argument_valid = req_argument_valid & ~(hs_a & ~hold);
        req_feedback_valid = req_feedback_valid & ~hs_f;
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy && n < bound) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic collect(input int n, input int bound);
        logic prev;
        int   gap, cyc;
        st_grant.delete();
        st_train.delete();
        st_gap.delete();
        prev = busy;
        gap  = 0;
        cyc  = 0;
        while (st_grant.size() < n && cyc < bound) begin
            tick();
            cyc++;
            if (busy && !prev) begin
                st_grant.push_back(int'(grant));
                st_train.push_back(int'(logistic_train));
                st_gap.push_back(gap);
                gap = 0;
            end else if (!busy) begin
                gap++;
            end
            prev = busy;
        end
        chk("collect_timeout", 32'(st_grant.size()), 32'(n));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_handshakes"},
            {argument_valid, feedback_valid, activation_ready, delta_ready,
             req_argument_ready, req_feedback_ready, req_activation_valid, req_delta_valid}, '0);
        chk({tag, "_status"}, {busy, logistic_train, grant}, '0);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1);
    end

    initial begin
        reset                = 1'b0;
        train                = 1'b0;
        hold                 = '0;
        req_argument_valid   = '0;
        req_argument_data    = '0;
        req_feedback_valid   = '0;
        req_feedback_data    = '0;
        req_activation_ready = '1;
        req_delta_ready      = '1;
        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b1;
        tick();
        chk("idle_after_reset", 32'(busy), 32'd0);

        // Single forward pass
        expect_out(0, 0, 16'h0080);
        req_argument_data[0]  = 16'h0000;
        req_argument_valid[0] = 1'b1;
        #1;
        chk("grant_not_comb", {busy, argument_valid, req_argument_ready}, '0);
        tick();
        chk("t1_argument", {busy, logistic_train, grant, argument_valid, req_argument_ready},
            9'b1_0_00_1_0001);
        wait_idle(20);

        // Contention after reset: 1 & 2, then 2 & 3
        pulse_reset();
        expect_out(0, 1, 16'h0011);
        expect_out(0, 2, 16'h0022);
        req_argument_data[1] = 16'h0011;
        req_argument_data[2] = 16'h0022;
        req_argument_valid   = 4'b0110;
        collect(2, 30);
        if (st_grant.size() == 2) begin
            chk("c1_first", 32'(st_grant[0]), 32'd1);
            chk("c1_second", 32'(st_grant[1]), 32'd2);
            chk("c1_gap", 32'(st_gap[1]), 32'd1);
        end
        wait_idle(20);
        pulse_reset();
        expect_out(0, 2, 16'h0023);
        expect_out(0, 3, 16'h0034);
        req_argument_data[2] = 16'h0023;
        req_argument_data[3] = 16'h0034;
        req_argument_valid   = 4'b1100;
        collect(2, 30);
        if (st_grant.size() == 2) begin
            chk("c2_first", 32'(st_grant[0]), 32'd2);
            chk("c2_second", 32'(st_grant[1]), 32'd3);
            chk("c2_gap", 32'(st_gap[1]), 32'd1);
        end
        wait_idle(20);

        // Training pass on req 3 while req 0 waits
        expect_out(0, 3, 16'h00ff);
        expect_out(1, 3, 16'h0000);
        expect_out(0, 0, 16'h0044);
        train                 = 1'b1;
        req_argument_data[3]  = 16'h0600;
        req_argument_valid[3] = 1'b1;
        tick();
        chk("t3_grant", {grant, logistic_train}, {2'd3, 1'b1});
        train                 = 1'b0;
        req_argument_data[0]  = 16'h0044;
        req_argument_valid[0] = 1'b1;
        req_feedback_data[3]  = 16'hfe00;
        req_feedback_valid[3] = 1'b1;
        collect(1, 30);
        if (st_grant.size() == 1) begin
            chk("t3_next_grant", 32'(st_grant[0]), 32'd0);
            chk("t3_next_train", 32'(st_train[0]), 32'd0);
            chk("t3_gap", 32'(st_gap[0]), 32'd1);
        end
        wait_idle(20);

        // Reset while in FEEDBACK abandons the transaction
        expect_out(0, 2, 16'h0002);
        train                 = 1'b1;
        req_argument_data[2]  = 16'h0002;
        req_argument_valid[2] = 1'b1;
        tick();
        for (int n = 0; n < 10 && req_feedback_ready != 4'b0100; n++) tick();
        chk("t4_in_feedback", 32'(req_feedback_ready), 32'h4);
        reset = 1'b0;
        #1;
        check_reset_outputs("midreset");
        tick();
        reset = 1'b1;
        train = 1'b0;
        expect_out(0, 0, 16'h0055);
        expect_out(0, 3, 16'h0066);
        req_argument_data[0] = 16'h0055;
        req_argument_data[3] = 16'h0066;
        req_argument_valid   = 4'b1001;
        collect(2, 30);
        if (st_grant.size() == 2) begin
            chk("t4_first", 32'(st_grant[0]), 32'd0);
            chk("t4_second", 32'(st_grant[1]), 32'd3);
        end
        wait_idle(20);

        // Fairness: all four continuously valid
        for (int k = 0; k < 6; k++) expect_out(0, k % 4, 16'(16'h00a0 + (k % 4)));
        for (int k = 0; k < N; k++) req_argument_data[k] = 16'(16'h00a0 + k);
        hold               = '1;
        req_argument_valid = '1;
        collect(6, 80);
        if (st_grant.size() == 6) begin
            for (int k = 0; k < 6; k++) chk("fair_grant", 32'(st_grant[k]), 32'(k % 4));
            for (int k = 1; k < 6; k++) chk("fair_gap", 32'(st_gap[k]), 32'd1);
        end
        hold               = '0;
        req_argument_valid = 4'b0010;
        wait_idle(20);
        repeat (3) tick();
        chk("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
